// File: rtl/reset_seq_pkg.sv
// Shared constants for the staged reset sequencer: state encoding and widths.
package reset_seq_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ASSERT   = 3'd0;
    localparam logic [STATE_W-1:0] WAIT_ACK = 3'd1;
    localparam logic [STATE_W-1:0] GAP      = 3'd2;
    localparam logic [STATE_W-1:0] RUN      = 3'd3;

endpackage

// File: rtl/reset_sequencer_seq_counter.sv
// Enable-qualified up counter with synchronous clear and terminal compare,
// shared by the hold, gap and acknowledge-timeout phases.
module seq_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic             hit_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (clr) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

    assign hit_c = (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domains, then release them in index order,
// waiting for each domain's acknowledge (with timeout) before the next.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic                   clk_enable,
    input  logic                   soft_reset_req,
    input  logic [NUM_DOMAINS-1:0] done_ack,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   seq_done,
    output logic                   timeout_err,
    output logic [STATE_W-1:0]     seq_state
);

    localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int unsigned ACK_EXT = 1 << IDX_W;

    logic [STATE_W-1:0]     state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [NUM_DOMAINS-1:0] dr_nxt;
    logic                   done_nxt;
    logic                   terr_nxt;
    logic                   cnt_clr_c;
    logic [CNT_WIDTH-1:0]   cnt_term_c;
    logic                   cnt_hit_c;
    logic [ACK_EXT-1:0]     ack_ext;
    logic                   ack_c;
    logic                   last_c;

    // Zero-extend so every idx value selects a defined bit.
    assign ack_ext = ACK_EXT'(done_ack);
    assign ack_c   = ack_ext[idx];
    assign last_c  = (idx == IDX_W'(NUM_DOMAINS - 1));

    seq_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (sync_reset),
        .en    (clk_enable),
        .clr   (cnt_clr_c),
        .term  (cnt_term_c),
        .hit_c (cnt_hit_c)
    );

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        dr_nxt     = domain_reset;
        done_nxt   = seq_done;
        terr_nxt   = timeout_err;
        cnt_clr_c  = 1'b0;
        cnt_term_c = '0;
        case (state)
            ASSERT: begin
                cnt_term_c = CNT_WIDTH'(HOLD_CYCLES - 1);
                if (cnt_hit_c) begin
                    cnt_clr_c = 1'b1;
                    dr_nxt[0] = 1'b0;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                cnt_term_c = CNT_WIDTH'(ACK_TIMEOUT - 1);
                // A coincident acknowledge wins over the timeout.
                if (ack_c || cnt_hit_c) begin
                    cnt_clr_c = 1'b1;
                    if (!ack_c) begin
                        terr_nxt = 1'b1;
                    end
                    if (last_c) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                cnt_term_c = CNT_WIDTH'(GAP_CYCLES - 1);
                if (cnt_hit_c) begin
                    cnt_clr_c = 1'b1;
                    idx_nxt   = idx + IDX_W'(1);
                    dr_nxt    = domain_reset & ~(NUM_DOMAINS'(1) << idx_nxt);
                    state_nxt = WAIT_ACK;
                end
            end
            RUN: begin
                cnt_clr_c = 1'b1;
                dr_nxt    = '0;
                done_nxt  = 1'b1;
                if (soft_reset_req) begin
                    dr_nxt    = '1;
                    done_nxt  = 1'b0;
                    terr_nxt  = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = ASSERT;
                end
            end
            default: begin
                cnt_clr_c = 1'b1;
                dr_nxt    = '1;
                done_nxt  = 1'b0;
                idx_nxt   = '0;
                state_nxt = ASSERT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state        <= ASSERT;
            idx          <= '0;
            domain_reset <= '1;
            seq_done     <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (clk_enable) begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            domain_reset <= dr_nxt;
            seq_done     <= done_nxt;
            timeout_err  <= terr_nxt;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: per-edge outputs compared against
// release/acknowledge event times computed from the stimulus trace.
module tb_reset_sequencer;

    localparam int unsigned ND    = 3;
    localparam int unsigned HOLD  = 16;
    localparam int unsigned GAPC  = 4;
    localparam int unsigned ACKTO = 8;
    localparam int unsigned CW    = 8;
    localparam int          MAXN  = 160;
    localparam int          BIG   = 1000000;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic          clk_enable;
    logic          soft_reset_req;
    logic [ND-1:0] done_ack;
    logic [ND-1:0] domain_reset;
    logic          seq_done;
    logic          timeout_err;
    logic [2:0]    seq_state;

    int checks   = 0;
    int failures = 0;

    logic          en_a   [MAXN];
    logic [ND-1:0] ack_a  [MAXN];
    logic          soft_a [MAXN];

    reset_sequencer #(
        .NUM_DOMAINS (ND),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAPC),
        .ACK_TIMEOUT (ACKTO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk            (clk),
        .sync_reset     (sync_reset),
        .clk_enable     (clk_enable),
        .soft_reset_req (soft_reset_req),
        .done_ack       (done_ack),
        .domain_reset   (domain_reset),
        .seq_done       (seq_done),
        .timeout_err    (timeout_err),
        .seq_state      (seq_state)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            en_a[i]   = 1'b1;
            ack_a[i]  = '1;
            soft_a[i] = 1'b0;
        end
    endtask

    task automatic do_sync_reset();
        sync_reset     = 1'b1;
        clk_enable     = 1'b1;
        soft_reset_req = 1'b0;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
    endtask

    // Edge 0 is the first enabled-or-not edge after reset/soft reset took effect.
    task automatic run_segment(input string tag, input int n);
        int en_pos[$];
        int rel[ND];
        int comp[ND];
        bit to[ND];
        int p, pc, q, k;
        logic [ND-1:0] exp_dr;
        logic          exp_done, exp_terr;
        logic [2:0]    exp_st;

        for (int i = 0; i < ND; i++) begin
            rel[i] = BIG; comp[i] = BIG; to[i] = 1'b0;
        end
        for (int e = 0; e < n; e++) if (en_a[e]) en_pos.push_back(e);

        p = HOLD - 1;
        if (p < en_pos.size()) rel[0] = en_pos[p];
        for (int i = 0; i < ND; i++) begin
            if (rel[i] == BIG) continue;
            pc = -1;
            for (int j = 1; j <= int'(ACKTO); j++) begin
                q = p + j;
                if (q >= en_pos.size()) break;
                if (ack_a[en_pos[q]][i]) begin
                    comp[i] = en_pos[q]; pc = q; break;
                end
                if (j == int'(ACKTO)) begin
                    comp[i] = en_pos[q]; to[i] = 1'b1; pc = q;
                end
            end
            if (pc < 0) continue;
            if (i < ND - 1) begin
                q = pc + GAPC;
                if (q < en_pos.size()) begin
                    rel[i+1] = en_pos[q]; p = q;
                end
            end
        end

        for (int e = 0; e < n; e++) begin
            clk_enable     = en_a[e];
            done_ack       = ack_a[e];
            soft_reset_req = soft_a[e];
            @(posedge clk);
            #1;
            exp_terr = 1'b0;
            k = 0;
            for (int i = 0; i < ND; i++) begin
                exp_dr[i] = (e < rel[i]);
                if (to[i] && e >= comp[i]) exp_terr = 1'b1;
                if (rel[i] <= e) k = i;
            end
            exp_done = (e >= comp[ND-1]);
            if (e < rel[0])          exp_st = 3'd0;
            else if (e < comp[k])    exp_st = 3'd1;
            else if (k == ND - 1)    exp_st = 3'd3;
            else                     exp_st = 3'd2;

            checks++;
            if (domain_reset !== exp_dr) begin
                failures++;
                $display("FAIL %s edge %0d domain_reset got %b want %b", tag, e, domain_reset, exp_dr);
            end
            checks++;
            if (seq_done !== exp_done) begin
                failures++;
                $display("FAIL %s edge %0d seq_done got %b want %b", tag, e, seq_done, exp_done);
            end
            checks++;
            if (timeout_err !== exp_terr) begin
                failures++;
                $display("FAIL %s edge %0d timeout_err got %b want %b", tag, e, timeout_err, exp_terr);
            end
            checks++;
            if (seq_state !== exp_st) begin
                failures++;
                $display("FAIL %s edge %0d seq_state got %0d want %0d", tag, e, seq_state, exp_st);
            end
        end
        clk_enable     = 1'b1;
        soft_reset_req = 1'b0;
        done_ack       = '1;
    endtask

    task automatic test_reset();
        sync_reset     = 1'b1;
        clk_enable     = 1'b0;
        soft_reset_req = 1'b0;
        done_ack       = '0;
        @(posedge clk);
        #1;
        checks++;
        if (domain_reset !== 3'b111) begin
            failures++;
            $display("FAIL reset domain_reset got %b want 111", domain_reset);
        end
        checks++;
        if (seq_done !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset flags got done=%b terr=%b want 0 0", seq_done, timeout_err);
        end
        checks++;
        if (seq_state !== 3'd0) begin
            failures++;
            $display("FAIL reset seq_state got %0d want 0", seq_state);
        end
        sync_reset = 1'b0;
    endtask

    task automatic test_nominal();
        clear_stim();
        do_sync_reset();
        run_segment("nominal", 34);
    endtask

    task automatic test_enable_gating();
        clear_stim();
        for (int e = 5; e < 15; e++) en_a[e] = 1'b0;
        do_sync_reset();
        run_segment("gating", 45);
    endtask

    task automatic test_timeout();
        clear_stim();
        for (int e = 0; e < MAXN; e++) ack_a[e][1] = 1'b0;
        do_sync_reset();
        run_segment("timeout", 45);
    endtask

    // Runs from RUN with timeout_err set (left by test_timeout).
    task automatic test_soft_reset();
        clk_enable     = 1'b0;
        soft_reset_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (seq_state !== 3'd3 || seq_done !== 1'b1) begin
            failures++;
            $display("FAIL soft_gated state got %0d done %b want 3 1", seq_state, seq_done);
        end
        clk_enable = 1'b1;
        @(posedge clk);
        #1;
        soft_reset_req = 1'b0;
        checks++;
        if (domain_reset !== 3'b111 || seq_state !== 3'd0) begin
            failures++;
            $display("FAIL soft_reset dr got %b state %0d want 111 0", domain_reset, seq_state);
        end
        checks++;
        if (seq_done !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL soft_reset flags got done=%b terr=%b want 0 0", seq_done, timeout_err);
        end
        clear_stim();
        soft_a[18] = 1'b1;
        run_segment("soft_rerun", 34);
    endtask

    task automatic test_mid_reset();
        clear_stim();
        for (int e = 0; e < MAXN; e++) ack_a[e][1] = 1'b0;
        do_sync_reset();
        run_segment("mid_pre", 23);
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        checks++;
        if (domain_reset !== 3'b111 || seq_state !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset dr got %b state %0d want 111 0", domain_reset, seq_state);
        end
        clear_stim();
        run_segment("mid_post", 34);
    endtask

    task automatic test_collision();
        clear_stim();
        for (int e = 0; e < 23; e++) ack_a[e][0] = 1'b0;
        do_sync_reset();
        run_segment("collision", 40);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            for (int e = 0; e < 120; e++) begin
                en_a[e] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < ND; i++) ack_a[e][i] = ($urandom_range(0, 2) == 0);
            end
            do_sync_reset();
            run_segment($sformatf("random%0d", r), 120);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_enable_gating();
        test_timeout();
        test_soft_reset();
        test_mid_reset();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
